// File: rtl/ram_host_arbiter_if.sv
// Host-side request/response bus and RAM-port bus of the two-host RAM arbiter.
// The slave modport is the arbiter's view; master is the hosts/RAM side.
interface ram_host_arbiter_if;
    logic [1:0]       h_req_i;
    logic [1:0]       h_we_i;
    logic [1:0][3:0]  h_be_i;
    logic [1:0][31:0] h_addr_i;
    logic [1:0][31:0] h_wdata_i;
    logic [1:0]       h_gnt_o;
    logic [1:0]       h_rvalid_o;
    logic [1:0]       h_err_o;
    logic [31:0]      h_rdata_o;

    logic             ram_req_o;
    logic             ram_we_o;
    logic [3:0]       ram_be_o;
    logic [31:0]      ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic             ram_rvalid_i;
    logic [31:0]      ram_rdata_i;

    modport slave (
        input  h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
        input  ram_rvalid_i, ram_rdata_i,
        output h_gnt_o, h_rvalid_o, h_err_o, h_rdata_o,
        output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
        output ram_rvalid_i, ram_rdata_i,
        input  h_gnt_o, h_rvalid_o, h_err_o, h_rdata_o,
        input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/ram_host_arbiter.sv
// Round-robin two-host arbiter in front of one fixed-latency RAM port.
// Out-of-window accesses are answered with an error response without reaching the RAM.
module ram_host_arbiter #(
    parameter logic [31:0] BaseAddr = 32'h0010_0000,
    parameter int unsigned Depth    = 128
) (
    input logic               clk_i,
    input logic               rst_ni,
    ram_host_arbiter_if.slave bus
);

    // Window bounds held in 33 bits so a window ending at 2^32 still compares correctly.
    localparam logic [32:0] WinLo = {1'b0, BaseAddr};
    localparam logic [32:0] WinHi = {1'b0, BaseAddr} + 33'(Depth * 4);

    function automatic logic in_window(input logic [31:0] addr);
        logic [32:0] word_addr;
        word_addr = {1'b0, addr[31:2], 2'b00};
        return (word_addr >= WinLo) && (word_addr < WinHi);
    endfunction

    logic       rr_last;
    logic [1:0] gnt_p0;
    logic       win_p0;
    logic       any_gnt_p0;
    logic       hit_p0;

    logic       resp_vld_p1;
    logic       resp_host_p1;
    logic       resp_err_p1;
    logic [1:0] resp_sel_p1;

    // ---- p0: arbitration and request forwarding (combinational) ----
    always_comb begin
        gnt_p0 = bus.h_req_i;
        if (bus.h_req_i == 2'b11) begin
            gnt_p0 = rr_last ? 2'b01 : 2'b10;
        end
    end

    assign win_p0     = gnt_p0[1];
    assign any_gnt_p0 = |gnt_p0;
    assign hit_p0     = in_window(bus.h_addr_i[win_p0]);

    assign bus.h_gnt_o     = gnt_p0;
    assign bus.ram_req_o   = any_gnt_p0 & hit_p0;
    assign bus.ram_we_o    = bus.h_we_i[win_p0];
    assign bus.ram_be_o    = bus.h_be_i[win_p0];
    assign bus.ram_addr_o  = bus.h_addr_i[win_p0];
    assign bus.ram_wdata_o = bus.h_wdata_i[win_p0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last      <= 1'b1;
            resp_vld_p1  <= 1'b0;
            resp_host_p1 <= 1'b0;
            resp_err_p1  <= 1'b0;
        end else begin
            resp_vld_p1 <= any_gnt_p0;
            if (any_gnt_p0) begin
                rr_last      <= win_p0;
                resp_host_p1 <= win_p0;
                resp_err_p1  <= ~hit_p0;
            end
        end
    end

    // ---- p1: response routing to the host granted in the previous cycle ----
    assign resp_sel_p1 = resp_vld_p1 ? (resp_host_p1 ? 2'b10 : 2'b01) : 2'b00;

    assign bus.h_rvalid_o = resp_sel_p1;
    assign bus.h_err_o    = resp_err_p1 ? resp_sel_p1 : 2'b00;
    assign bus.h_rdata_o  = (resp_vld_p1 && !resp_err_p1) ? bus.ram_rdata_i : 32'h0;

    // The RAM answers with fixed latency, so its rvalid must mirror our in-range response.
    a_ram_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.ram_rvalid_i == (resp_vld_p1 && !resp_err_p1));
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.h_gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.h_rvalid_o));

endmodule

// File: doc/ram_host_arbiter.md
Name: ram_host_arbiter

Overview:
- Two-host request arbiter that sits directly upstream of one port of the dual-port 32-bit RAM.
- Host 0 is typically the core data port; host 1 is a debug/loader or DMA master.
- Grants one request per cycle with round-robin fairness and forwards it to the RAM port.
- Routes the RAM response back to the granted host one cycle later, and produces error responses for addresses outside the RAM window without touching the RAM.

Parameters:
- BaseAddr, 32'h0010_0000, byte base address of the RAM window; must be aligned to Depth*4.
- Depth, 128, RAM depth in 32-bit words; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- h_req_i  in  2  per-host request (bit n = host n)
- h_we_i  in  2  per-host write enable
- h_be_i  in  2x4  per-host byte enables
- h_addr_i  in  2x32  per-host byte address
- h_wdata_i  in  2x32  per-host write data
- h_gnt_o  out  2  per-host grant (combinational, same cycle as req)
- h_rvalid_o  out  2  per-host response valid
- h_err_o  out  2  per-host error flag, qualified by h_rvalid_o
- h_rdata_o  out  32  shared response data, qualified by h_rvalid_o
- ram_req_o  out  1  RAM port request
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  32  RAM byte address (passed through unmodified)
- ram_wdata_o  out  32  RAM write data
- ram_rvalid_i  in  1  RAM response valid (1 cycle after ram_req_o)
- ram_rdata_i  in  32  RAM read data

Behaviour:
- Reset values: rr_last = host 1, so host 0 wins the first contention. resp_valid=0, resp_host=0, resp_err=0. h_rvalid_o=0, h_err_o=0, h_rdata_o=0.
- Arbitration (combinational):
  - Single requester → granted.
  - Both requesting → grant the host ≠ rr_last.
  - At most one h_gnt_o bit high; h_gnt_o=0 when no request.
- rr_last updates to the granted host on every grant cycle; it holds otherwise.
- In-range check: BaseAddr ≤ addr < BaseAddr+Depth*4, compared on the full 32 bits. addr[1:0] is ignored.
- Granted and in range:
  - ram_req_o=1; we/be/addr/wdata are muxed from the winner.
  - resp_valid←1, resp_host←winner, resp_err←0.
- Granted and out of range:
  - ram_req_o=0; the access is dropped and the write has no side effect.
  - resp_valid←1, resp_host←winner, resp_err←1.
- No grant: ram_req_o=0, resp_valid←0. When ram_req_o=0, the ram_we/be/addr/wdata outputs hold the host 0 mux values, which are don't-care.
- Response, cycle N+1 after a grant in cycle N:
  - h_rvalid_o[resp_host]=1; all other bits 0.
  - h_err_o[resp_host]=resp_err.
  - h_rdata_o = ram_rdata_i when resp_err=0; 32'h0 when resp_err=1.
  - Writes also return exactly one rvalid.
- Throughput: one grant per cycle, back-to-back. Response latency is exactly 1 cycle. No outstanding-request buffering is needed because the RAM latency is fixed.
- ram_rvalid_i is used only as a consistency check. Assertions:
  - ram_rvalid_i == (resp_valid && !resp_err).
  - h_gnt_o is one-hot-or-zero.
  - h_rvalid_o is one-hot-or-zero.
- Simultaneous events: a new grant in cycle N+1 coexists with the response for cycle N; the two do not interact.
- Reset mid-operation: a pending response is discarded, with no rvalid after reset deassertion, and rr_last returns to its reset value.
- Hosts must hold req/we/be/addr/wdata stable until granted; this is not checked.

Test Plan:
1. Host 0 writes 32'hDEADBEEF to BaseAddr+8 with be=4'hF, then reads BaseAddr+8 → gnt[0] in the same cycle as each req; h_rvalid_o[0] one cycle later; read returns 32'hDEADBEEF with err=0.
2. Both hosts request continuously for 6 cycles (in-range reads) → grants alternate 0,1,0,1,0,1; each h_rvalid_o arrives one cycle later on the matching host.
3. Host 1 writes to BaseAddr+Depth*4, then reads it back and also reads BaseAddr-4 → ram_req_o stays 0 throughout; h_rvalid_o[1]=1 with h_err_o[1]=1 and rdata 0 for each access; RAM contents unchanged.
4. Host 0 does a byte write of be=4'b0010, wdata=32'h0000AB00 over a word holding 32'h11223344, then a read → read returns 32'h1122AB44.
5. Reset asserted in the cycle after a granted read → no h_rvalid_o after reset release; the first contention after reset grants host 0.
6. Host 0 issues back-to-back reads of BaseAddr+0 and BaseAddr+4 over 2 cycles while host 1 is idle → 2 grants, 2 consecutive h_rvalid_o[0] pulses carrying the correct data in order.
